// File: rtl/img_key_highlight_ctrl.sv
// Key-highlight controller for the VGA overlay: decodes PS/2 set-2 bytes and commits
// a one-hot highlight on each frame tick, holding it for HOLD_FRAMES frames.
// Optional build macro HOLD_WHILE_PRESSED_EN: the highlight is frozen until the key is released.
module img_key_highlight_ctrl #(
    parameter int HOLD_FRAMES = 30,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       frame_tick,
    output logic       aI,
    output logic       bI,
    output logic       cI,
    output logic       dI,
    output logic       upI,
    output logic       downI,
    output logic       leftI,
    output logic       rightI,
    output logic       active,
    output logic       pending
);

    localparam logic [CNT_W-1:0] HOLD_LD = (HOLD_FRAMES == 0) ? CNT_W'(1) : CNT_W'(HOLD_FRAMES);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       hl;
    logic [2:0]       pend_idx;
    logic             brk;
    logic             dec_hit;
    logic [2:0]       dec_idx;
    logic             is_e0, is_f0, make, rel, frozen;

    always_comb begin
        dec_hit = 1'b1;
        dec_idx = 3'd0;
        case (key_code)
            8'h1C: dec_idx = 3'd0;
            8'h32: dec_idx = 3'd1;
            8'h21: dec_idx = 3'd2;
            8'h23: dec_idx = 3'd3;
            8'h75: dec_idx = 3'd4;
            8'h72: dec_idx = 3'd5;
            8'h6B: dec_idx = 3'd6;
            8'h74: dec_idx = 3'd7;
            default: dec_hit = 1'b0;
        endcase
    end

    assign is_e0 = (key_code == 8'hE0);
    assign is_f0 = (key_code == 8'hF0);
    // E0 is transparent: it neither starts nor ends a break sequence
    assign make  = key_valid && !is_e0 && !is_f0 && !brk && dec_hit;
    assign rel   = key_valid && !is_e0 && !is_f0 && brk;

`ifdef HOLD_WHILE_PRESSED_EN
    logic       held, pend_down;
    logic [2:0] shown_idx;
    logic       rel_pend, rel_shown;

    assign rel_pend  = rel && dec_hit && (dec_idx == pend_idx);
    assign rel_shown = rel && dec_hit && (dec_idx == shown_idx);
    assign frozen    = held;

    // Track whether the pending key is still down so a key released before its
    // commit does not freeze the highlight forever.
    always_ff @(posedge clk) begin
        if (reset) begin
            held      <= 1'b0;
            pend_down <= 1'b0;
            shown_idx <= 3'd0;
        end else begin
            if (make)          pend_down <= 1'b1;
            else if (rel_pend) pend_down <= 1'b0;
            if (frame_tick && pending) begin
                held      <= pend_down && !rel_pend;
                shown_idx <= pend_idx;
            end else if (rel_shown) begin
                held <= 1'b0;
            end
        end
    end
`else
    assign frozen = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hl       <= '0;
            pend_idx <= 3'd0;
            pending  <= 1'b0;
            brk      <= 1'b0;
        end else begin
            if (key_valid && is_f0) brk <= 1'b1;
            else if (rel)           brk <= 1'b0;

            // A make in the tick cycle survives as the next frame's pending key
            if (make) begin
                pending  <= 1'b1;
                pend_idx <= dec_idx;
            end else if (frame_tick) begin
                pending  <= 1'b0;
            end

            if (frame_tick) begin
                if (pending) begin
                    state <= SHOW;
                    cnt   <= HOLD_LD;
                    hl    <= 8'b1 << pend_idx;
                end else if (state == SHOW && !frozen) begin
                    if (cnt > CNT_W'(1)) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                        hl    <= '0;
                    end
                end
            end
        end
    end

    assign {rightI, leftI, downI, upI, dI, cI, bI, aI} = hl;
    assign active = (state == SHOW);

endmodule
